// File: rtl/mcpu_ram_master.sv
// mcpu_ram_master: turns CPU load/store requests into we/re/addr/datawr sequences for the MCPU RAM
// controller, and runs a 1-per-cycle instruction fetch pipeline. Optional write read-back check: MCPU_RAM_WRITE_VERIFY_EN.
module mcpu_ram_master #(
  parameter int WORD_SIZE  = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int RD_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [WORD_SIZE-1:0]  req_wdata,
  output logic                  rsp_valid,
  output logic [WORD_SIZE-1:0]  rsp_data,
  input  logic                  fetch_valid,
  input  logic [ADDR_WIDTH-1:0] fetch_addr,
  output logic                  fetch_rsp_valid,
  output logic [WORD_SIZE-1:0]  fetch_instr,
  output logic                  we,
  output logic                  re,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [WORD_SIZE-1:0]  datawr,
  input  logic [WORD_SIZE-1:0]  datard,
  output logic [ADDR_WIDTH-1:0] instraddr,
  input  logic [WORD_SIZE-1:0]  instrrd,
  output logic                  wr_err
);

  generate
    if (RD_LATENCY < 1 || RD_LATENCY > 15) begin : g_bad_latency
      $error("mcpu_ram_master: RD_LATENCY must be in 1..15");
    end
  endgenerate

  // Handshake: a request transfers on a rising edge where req_valid and req_ready are both 1;
  // the requester keeps req_valid and its payload stable until that edge. rsp_valid is a 1-cycle strobe.
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WRITE  = 3'd1,
    S_READ   = 3'd2,
`ifdef MCPU_RAM_WRITE_VERIFY_EN
    S_VERIFY = 3'd3,
`endif
    S_RESP   = 3'd4
  } state_t;

  localparam logic [3:0] LAT_INIT = 4'(RD_LATENCY - 1);

  state_t                state_q, state_d;
  logic [3:0]            lat_cnt_q, lat_cnt_d;
  logic                  req_ready_q, req_ready_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [WORD_SIZE-1:0]  rsp_data_q, rsp_data_d;
  logic                  we_q, we_d;
  logic                  re_q, re_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [WORD_SIZE-1:0]  datawr_q, datawr_d;
  logic [ADDR_WIDTH-1:0] instraddr_q, instraddr_d;
  logic                  fetch_pend_q, fetch_pend_d;
  logic                  fetch_rsp_valid_q, fetch_rsp_valid_d;
  logic [WORD_SIZE-1:0]  fetch_instr_q, fetch_instr_d;
`ifdef MCPU_RAM_WRITE_VERIFY_EN
  logic                  wr_err_q, wr_err_d;
`endif

  always_comb begin
    state_d     = state_q;
    lat_cnt_d   = lat_cnt_q;
    req_ready_d = req_ready_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    we_d        = 1'b0;
    re_d        = 1'b0;
    addr_d      = addr_q;
    datawr_d    = datawr_q;
`ifdef MCPU_RAM_WRITE_VERIFY_EN
    wr_err_d    = wr_err_q;
`endif
    case (state_q)
      S_IDLE: begin
        req_ready_d = 1'b1;
        if (req_valid && req_ready_q) begin
          req_ready_d = 1'b0;
          addr_d      = req_addr;
          if (req_we) begin
            state_d  = S_WRITE;
            we_d     = 1'b1;
            datawr_d = req_wdata;
          end else begin
            state_d   = S_READ;
            re_d      = 1'b1;
            lat_cnt_d = LAT_INIT;
          end
        end
      end
      S_WRITE: begin
`ifdef MCPU_RAM_WRITE_VERIFY_EN
        state_d   = S_VERIFY;
        re_d      = 1'b1;
        lat_cnt_d = LAT_INIT;
`else
        // datawr_q still holds the store data, so it doubles as the response payload.
        state_d     = S_RESP;
        rsp_valid_d = 1'b1;
        rsp_data_d  = datawr_q;
`endif
      end
      S_READ: begin
        if (lat_cnt_q == 4'd0) begin
          state_d     = S_RESP;
          rsp_valid_d = 1'b1;
          rsp_data_d  = datard;
        end else begin
          re_d      = 1'b1;
          lat_cnt_d = lat_cnt_q - 4'd1;
        end
      end
`ifdef MCPU_RAM_WRITE_VERIFY_EN
      S_VERIFY: begin
        if (lat_cnt_q == 4'd0) begin
          state_d     = S_RESP;
          rsp_valid_d = 1'b1;
          rsp_data_d  = datard;
          if (datard != datawr_q) wr_err_d = 1'b1;
        end else begin
          re_d      = 1'b1;
          lat_cnt_d = lat_cnt_q - 4'd1;
        end
      end
`endif
      S_RESP: begin
        state_d     = S_IDLE;
        req_ready_d = 1'b1;
      end
      default: begin
        state_d     = S_IDLE;
        req_ready_d = 1'b1;
      end
    endcase
  end

  // Fetch path is independent of the data FSM: address stage, then data stage.
  always_comb begin
    instraddr_d       = fetch_valid ? fetch_addr : instraddr_q;
    fetch_pend_d      = fetch_valid;
    fetch_rsp_valid_d = fetch_pend_q;
    fetch_instr_d     = fetch_pend_q ? instrrd : fetch_instr_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q           <= S_IDLE;
      lat_cnt_q         <= 4'd0;
      req_ready_q       <= 1'b1;
      rsp_valid_q       <= 1'b0;
      rsp_data_q        <= '0;
      we_q              <= 1'b0;
      re_q              <= 1'b0;
      addr_q            <= '0;
      datawr_q          <= '0;
      instraddr_q       <= '0;
      fetch_pend_q      <= 1'b0;
      fetch_rsp_valid_q <= 1'b0;
      fetch_instr_q     <= '0;
`ifdef MCPU_RAM_WRITE_VERIFY_EN
      wr_err_q          <= 1'b0;
`endif
    end else begin
      state_q           <= state_d;
      lat_cnt_q         <= lat_cnt_d;
      req_ready_q       <= req_ready_d;
      rsp_valid_q       <= rsp_valid_d;
      rsp_data_q        <= rsp_data_d;
      we_q              <= we_d;
      re_q              <= re_d;
      addr_q            <= addr_d;
      datawr_q          <= datawr_d;
      instraddr_q       <= instraddr_d;
      fetch_pend_q      <= fetch_pend_d;
      fetch_rsp_valid_q <= fetch_rsp_valid_d;
      fetch_instr_q     <= fetch_instr_d;
`ifdef MCPU_RAM_WRITE_VERIFY_EN
      wr_err_q          <= wr_err_d;
`endif
    end
  end

  assign req_ready       = req_ready_q;
  assign rsp_valid       = rsp_valid_q;
  assign rsp_data        = rsp_data_q;
  assign we              = we_q;
  assign re              = re_q;
  assign addr            = addr_q;
  assign datawr          = datawr_q;
  assign instraddr       = instraddr_q;
  assign fetch_rsp_valid = fetch_rsp_valid_q;
  assign fetch_instr     = fetch_instr_q;
`ifdef MCPU_RAM_WRITE_VERIFY_EN
  assign wr_err          = wr_err_q;
`else
  assign wr_err          = 1'b0;
`endif

endmodule

// File: tb/tb_mcpu_ram_master.sv
// Bench for mcpu_ram_master: RAM/controller environment, transaction-level expectation model checked
// every cycle, directed scenarios with literal expectations, then randomized loads/stores/fetches.
module tb_mcpu_ram_master;
  localparam int AW = 8;
  localparam int WS = 8;
  localparam int RD_LAT = 3;
`ifdef MCPU_RAM_WRITE_VERIFY_EN
  localparam bit VER = 1'b1;
`else
  localparam bit VER = 1'b0;
`endif
  localparam logic [7:0] BAD_ADDR = 8'h20;

  logic clk, reset;
  logic req_valid, req_ready, req_we;
  logic [AW-1:0] req_addr;
  logic [WS-1:0] req_wdata;
  logic rsp_valid;
  logic [WS-1:0] rsp_data;
  logic fetch_valid, fetch_rsp_valid;
  logic [AW-1:0] fetch_addr;
  logic [WS-1:0] fetch_instr;
  logic we, re, wr_err;
  logic [AW-1:0] addr, instraddr;
  logic [WS-1:0] datawr, datard, instrrd;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  mcpu_ram_master #(.WORD_SIZE(WS), .ADDR_WIDTH(AW), .RD_LATENCY(RD_LAT)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .fetch_valid(fetch_valid), .fetch_addr(fetch_addr),
    .fetch_rsp_valid(fetch_rsp_valid), .fetch_instr(fetch_instr),
    .we(we), .re(re), .addr(addr), .datawr(datawr), .datard(datard),
    .instraddr(instraddr), .instrrd(instrrd), .wr_err(wr_err)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- RAM controller environment ----------------
  logic [WS-1:0] ram [0:255];
  logic [WS-1:0] ref_mem [0:255];
  int re_run = 0;

  function automatic logic [7:0] corrupt(input logic [7:0] a);
    return (a == BAD_ADDR) ? 8'hFF : 8'h00;
  endfunction

  always @(posedge clk) begin
    if (we) ram[addr] <= datawr;
    re_run <= re ? re_run + 1 : 0;
  end
  // Read data is only correct once re has been held for the full latency.
  assign datard  = (re && re_run >= RD_LAT - 1) ? (ram[addr] ^ corrupt(addr)) : ~ram[addr];
  assign instrrd = ram[instraddr];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- expectation model + per-cycle compare ----------------
  bit m_valid = 0;
  bit busy = 0;
  bit m_st, m_mis, m_err;
  int acc_cyc, rsp_len, k;
  logic [7:0] m_a, m_dw, m_rsp, m_rdata, m_fi;
  int fq_cyc[$];
  logic [WS-1:0] exp_q[$];
  logic e_we, e_re, e_rsp, e_fv;

  always @(negedge clk) begin
    if (m_valid) begin
      k     = cyc - acc_cyc;
      e_we  = busy && m_st && k == 1;
      e_re  = busy && ((!m_st && k >= 1 && k <= RD_LAT) ||
                       (m_st && VER && k >= 2 && k <= RD_LAT + 1));
      e_rsp = busy && k == rsp_len;
      if (e_rsp) begin
        m_rsp = m_rdata;
        if (m_mis) m_err = 1'b1;
      end
      e_fv = fq_cyc.size() > 0 && fq_cyc[0] == cyc;
      if (e_fv) begin
        m_fi = exp_q.pop_front();
        void'(fq_cyc.pop_front());
      end
      check("we", 32'(we), 32'(e_we));
      check("re", 32'(re), 32'(e_re));
      check("rsp_valid", 32'(rsp_valid), 32'(e_rsp));
      check("req_ready", 32'(req_ready), 32'(!busy));
      check("addr", 32'(addr), 32'(m_a));
      check("datawr", 32'(datawr), 32'(m_dw));
      check("rsp_data", 32'(rsp_data), 32'(m_rsp));
      check("wr_err", 32'(wr_err), 32'(m_err));
      check("fetch_rsp_valid", 32'(fetch_rsp_valid), 32'(e_fv));
      check("fetch_instr", 32'(fetch_instr), 32'(m_fi));
    end
    if (reset) begin
      m_valid = 1; busy = 0; m_a = 0; m_dw = 0; m_rsp = 0; m_err = 0; m_fi = 0;
      fq_cyc.delete(); exp_q.delete();
    end else if (m_valid) begin
      if (!busy && req_valid) begin
        busy = 1; acc_cyc = cyc; m_st = req_we; m_a = req_addr;
        if (req_we) begin
          m_dw = req_wdata;
          ref_mem[req_addr] = req_wdata;
          m_rdata = VER ? (req_wdata ^ corrupt(req_addr)) : req_wdata;
          rsp_len = VER ? RD_LAT + 2 : 2;
          m_mis   = VER && corrupt(req_addr) != 8'h00;
        end else begin
          m_rdata = ref_mem[req_addr] ^ corrupt(req_addr);
          rsp_len = RD_LAT + 1;
          m_mis   = 1'b0;
        end
      end else if (busy && k == rsp_len) begin
        busy = 0;
      end
      if (fetch_valid) begin
        fq_cyc.push_back(cyc + 2);
        exp_q.push_back(ref_mem[fetch_addr]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_req(input logic w, input logic [7:0] a, input logic [7:0] d, input bit hold,
                        output int acc, output int lat);
    bit got;
    got = 0; acc = -1; lat = -1;
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = w; req_addr = a; req_wdata = d;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (req_ready === 1'b1) begin got = 1; acc = cyc; break; end
    end
    if (!got) begin
      check("accept_timeout", 32'(got), 32'(1));
      req_valid = 1'b0;
    end else begin
      @(posedge clk); #1;
      if (!hold) req_valid = 1'b0;
      got = 0;
      for (int t = 0; t < 60; t++) begin
        @(negedge clk);
        if (rsp_valid === 1'b1) begin got = 1; lat = cyc - acc; break; end
      end
      if (!got) check("rsp_timeout", 32'(got), 32'(1));
    end
  endtask

  int acc, lat, acc2, lat2, rsp1, nrsp;
  bit got1;

  initial begin
    for (int i = 0; i < 256; i++) begin
      ram[i]     = 8'(i) ^ 8'h5C;
      ref_mem[i] = 8'(i) ^ 8'h5C;
    end
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    fetch_valid = 1'b0; fetch_addr = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_we", 32'(we), 32'(0));
    check("rst_re", 32'(re), 32'(0));
    check("rst_rsp_valid", 32'(rsp_valid), 32'(0));
    check("rst_req_ready", 32'(req_ready), 32'(1));
    check("rst_fetch_rsp_valid", 32'(fetch_rsp_valid), 32'(0));
    @(posedge clk); #1 reset = 1'b0;

    // Test 1: reset lands in the 2nd re cycle of a load.
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 8'h44;
    got1 = 0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (req_ready === 1'b1) begin got1 = 1; break; end
    end
    check("t1_accept", 32'(got1), 32'(1));
    @(posedge clk); #1 req_valid = 1'b0;
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("t1_we", 32'(we), 32'(0));
    check("t1_re", 32'(re), 32'(0));
    check("t1_rsp_valid", 32'(rsp_valid), 32'(0));
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check("t1_req_ready", 32'(req_ready), 32'(1));
    nrsp = 0;
    for (int t = 0; t < 8; t++) begin
      @(negedge clk);
      if (rsp_valid === 1'b1) nrsp++;
    end
    check("t1_no_rsp", 32'(nrsp), 32'(0));

    // Test 2: store 0xA5 to 0x10.
    do_req(1'b1, 8'h10, 8'hA5, 1'b0, acc, lat);
    check("t2_lat", 32'(lat), VER ? 32'(RD_LAT + 2) : 32'(2));
    check("t2_rsp_data", 32'(rsp_data), 32'h A5);

    // Test 3: load it back; store/load the all-ones address.
    do_req(1'b0, 8'h10, 8'h00, 1'b0, acc, lat);
    check("t3_lat", 32'(lat), 32'(RD_LAT + 1));
    check("t3_rsp_data", 32'(rsp_data), 32'h A5);
    do_req(1'b1, 8'hFF, 8'h5A, 1'b0, acc, lat);
    do_req(1'b0, 8'hFF, 8'h00, 1'b0, acc, lat);
    check("t3_ff_rsp_data", 32'(rsp_data), 32'h 5A);

    // Test 4: req_valid held through a load; next accept only right after RESP.
    do_req(1'b0, 8'h05, 8'h00, 1'b1, acc, lat);
    rsp1 = cyc;
    check("t4_lat", 32'(lat), 32'(RD_LAT + 1));
    check("t4_rsp_data", 32'(rsp_data), 32'h 59);
    do_req(1'b0, 8'h06, 8'h00, 1'b0, acc2, lat2);
    check("t4_next_accept", 32'(acc2 - rsp1), 32'(1));
    check("t4_rsp2_data", 32'(rsp_data), 32'h 5A);

    // Test 5: back-to-back fetches during a store.
    fork
      do_req(1'b1, 8'h30, 8'h77, 1'b0, acc, lat);
      begin
        @(posedge clk); #1 fetch_valid = 1'b1; fetch_addr = 8'h00;
        @(posedge clk); #1 fetch_addr = 8'h01;
        @(posedge clk); #1 fetch_addr = 8'h02;
        @(negedge clk);
        check("t5_fv0", 32'(fetch_rsp_valid), 32'(1));
        check("t5_fi0", 32'(fetch_instr), 32'h 5C);
        @(posedge clk); #1 fetch_valid = 1'b0;
        @(negedge clk);
        check("t5_fv1", 32'(fetch_rsp_valid), 32'(1));
        check("t5_fi1", 32'(fetch_instr), 32'h 5D);
        @(negedge clk);
        check("t5_fv2", 32'(fetch_rsp_valid), 32'(1));
        check("t5_fi2", 32'(fetch_instr), 32'h 5E);
        @(negedge clk);
        check("t5_fv_end", 32'(fetch_rsp_valid), 32'(0));
        check("t5_fi_hold", 32'(fetch_instr), 32'h 5E);
      end
    join

    // Test 6: store to the corrupting address, then a good store.
    do_req(1'b1, BAD_ADDR, 8'h3C, 1'b0, acc, lat);
    check("t6_lat", 32'(lat), VER ? 32'(RD_LAT + 2) : 32'(2));
    check("t6_rsp_data", 32'(rsp_data), VER ? 32'h C3 : 32'h 3C);
    check("t6_wr_err", 32'(wr_err), 32'(VER));
    do_req(1'b1, 8'h21, 8'h11, 1'b0, acc, lat);
    check("t6_wr_err_sticky", 32'(wr_err), 32'(VER));
    check("t6_good_rsp", 32'(rsp_data), 32'h 11);

    // Random phase: data traffic in 0x00-0x7F, fetches in 0x80-0xBF.
    fork
      begin
        for (int n = 0; n < 40; n++) begin
          do_req(1'($urandom_range(0, 1)), 8'($urandom_range(0, 127)), 8'($urandom),
                 1'($urandom_range(0, 1)), acc, lat);
          repeat ($urandom_range(0, 2)) @(posedge clk);
        end
        @(posedge clk); #1 req_valid = 1'b0;
      end
      begin
        for (int n = 0; n < 250; n++) begin
          @(posedge clk); #1;
          fetch_valid = 1'($urandom_range(0, 1));
          fetch_addr  = 8'($urandom_range(128, 191));
        end
        @(posedge clk); #1 fetch_valid = 1'b0;
      end
    join
    repeat (10) @(posedge clk);
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
